// File: rtl/mux_pkg.sv
// Shared constants for the mux select sequencer: channel count, select width,
// FSM state codes and the one-hot helper used to build the grant vector.
package mux_pkg;

    localparam int N_CH        = 4;
    localparam int SEL_W       = 2;
    localparam int DWELL_W_DEF = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return {{(N_CH-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester starting at pointer+1,
// wrapping, with the pointer itself checked last so a lone requester is re-picked.
module rr_pick
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] pointer,
    output logic             found,
    output logic [SEL_W-1:0] index
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate toward pointer+1 so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        index = pointer;
        cand  = pointer;
        for (int k = N_CH; k >= 1; k--) begin
            cand = pointer + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for a downstream registered 4:1 mux: grants a
// requester, holds it for dwell+1 cycles (or until it drops), then re-arbitrates.
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [N_CH-1:0]    req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic [N_CH-1:0]    grant,
    output logic               sel_change
);

    logic [0:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [SEL_W-1:0]   ptr;
    logic               found;
    logic [SEL_W-1:0]   pick;
    logic               hold_end;
    logic               do_grant;

    rr_pick u_pick (
        .req     (req),
        .pointer (ptr),
        .found   (found),
        .index   (pick)
    );

    // In IDLE every edge is an arbitration opportunity; in HOLD only at the
    // last dwell cycle or when the granted channel withdraws its request.
    assign hold_end = (state == ST_HOLD) ? ((cnt == '0) || !req[sel]) : 1'b1;
    assign do_grant = enable && hold_end && found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            grant      <= '0;
            sel_change <= 1'b0;
            cnt        <= '0;
            ptr        <= SEL_W'(N_CH - 1);
        end else begin
            sel_change <= 1'b0;
            if (!enable) begin
                state     <= ST_IDLE;
                sel_valid <= 1'b0;
                grant     <= '0;
            end else if (do_grant) begin
                state      <= ST_HOLD;
                sel        <= pick;
                ptr        <= pick;
                grant      <= sel_onehot(pick);
                sel_valid  <= 1'b1;
                sel_change <= 1'b1;
                cnt        <= dwell;
            end else if (hold_end) begin
                state     <= ST_IDLE;
                sel_valid <= 1'b0;
                grant     <= '0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 Parameter DWELL_W, default 4: width of the dwell input and the internal hold counter.
REQ-002 Port clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port enable  input  1  sequencing enable; 0 forces release to IDLE.
REQ-005 Port req  input  4  per-channel request; bit i requests selection of mux input i (0=a, 1=b, 2=c, 3=d).
REQ-006 Port dwell  input  DWELL_W  hold length minus one for each grant.
REQ-007 Port sel  output  2  select code driven to the downstream registered 4:1 mux.
REQ-008 Port sel_valid  output  1  high while sel reflects an active grant.
REQ-009 Port grant  output  4  one-hot copy of sel while sel_valid=1, else 0.
REQ-010 Port sel_change  output  1  one-cycle pulse on the cycle a new grant is issued.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 FSM states SHALL be IDLE and HOLD only.
REQ-013 IDLE: sel_valid=0 and grant=0; sel holds its last value.
REQ-014 IDLE -> HOLD on an edge where enable=1 and req!=0; the grant is visible on the next cycle (1-cycle latency).
REQ-015 Arbitration SHALL be round-robin: search starts at pointer+1 mod 4 and wraps; pointer = last granted channel.
REQ-016 If the only requester is the previously granted channel, it SHALL be re-granted.
REQ-017 On grant: sel=channel, grant=one-hot(channel), sel_valid=1, sel_change=1 for one cycle, counter loaded with dwell.
REQ-018 dwell SHALL be sampled only at grant; changes during HOLD are ignored.
REQ-019 HOLD SHALL last exactly dwell+1 cycles (dwell=0 gives 1 cycle) unless ended early.
REQ-020 Counter decrements once per HOLD cycle; hold ends on the cycle the counter is 0.
REQ-021 Early end: the granted req bit sampled 0 during HOLD ends the hold at that edge.
REQ-022 At hold end with enable=1 and req!=0: the next grant is issued at that edge (back-to-back, no sel_valid gap).
REQ-023 At hold end with req==0: -> IDLE.
REQ-024 enable=0 in any state: -> IDLE at the next edge; pointer retained.
REQ-025 Simultaneous hold end and new request on the same edge SHALL be treated as a single arbitration (REQ-022).
REQ-026 sel_change SHALL pulse on every grant, including a re-grant of the same channel.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, sel=0, sel_valid=0, grant=0, sel_change=0, counter=0, pointer=3 (first search starts at channel 0).
REQ-028 rst asserted mid-HOLD SHALL abort the grant immediately, without waiting for a clock.
REQ-029 After rst deasserts, the first grant SHALL occur no earlier than the first posedge clk with rst=0.

Structure
REQ-030 Shared package mux_pkg SHALL hold N_CH=4, SEL_W=2, the IDLE/HOLD state encodings, and the DWELL_W default.
REQ-031 Sub-module rr_pick (combinational: req[3:0], pointer[1:0] -> found, index[1:0]) SHALL implement the round-robin search.
REQ-032 The hold counter, pointer and FSM SHALL reside in mux_sel_sequencer.

Verification
REQ-033 Reset: rst pulse mid-HOLD, between clock edges -> sel=0, sel_valid=0, grant=0 immediately; first grant after release is channel 0 when req=4'b1111.
REQ-034 Round-robin: req=4'b1111, dwell=0, enable=1 -> sel sequence 0,1,2,3,0 on consecutive cycles, sel_valid held at 1, sel_change=1 every cycle.
REQ-035 Dwell: req=4'b0100, dwell=3 -> sel=2 for 4 cycles, then re-granted with sel_change=1; a dwell change to 7 mid-hold has no effect on the current hold.
REQ-036 Early release: req=4'b0011, dwell=9; channel 0 granted, req[0] dropped on hold cycle 2 -> sel=1 granted on the following cycle.
REQ-037 Enable drop: enable 1->0 during HOLD with sel=3 -> sel_valid=0 and grant=0 next cycle, sel stays 3; re-enable with req=4'b1001 -> channel 0 granted (wrap from pointer 3).
REQ-038 Idle: req=0, enable=1 for 10 cycles -> sel_valid and sel_change stay 0, sel unchanged.
